// File: rtl/fp_pkg.sv
// Shared floating-point format constants and stage types for the fp_mul blocks.
package fp_pkg;

  localparam int unsigned FP_W   = 24;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 15;
  localparam int unsigned PROD_W = 17;
  localparam int unsigned SUM_W  = 9;
  localparam int unsigned E_W    = 10;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  // S1 -> S2 payload: rounded mantissa plus a two's-complement exponent
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [E_W-1:0]    exp;
    logic [MANT_W-1:0] mant;
  } s1_t;

endpackage

// File: rtl/fp_mul_1.sv
// Back end of the 24-bit FP multiplier: normalize/round (S1), then exponent
// range check and pack (S2), with a valid/ready handshake on both sides.
module fp_mul_1
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product_i,
  input  logic              zero_flag_i,
  input  logic              sign_xor_i,
  input  logic [SUM_W-1:0]  sum_exp_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   result_o,
  output logic              ovf_o,
  output logic              uf_o
);

  localparam logic signed [E_W-1:0] EXP_MAX_E  = E_W'(EXP_MAX);
  localparam logic signed [E_W-1:0] EXP_ZERO_E = '0;

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  s1_t  s1_q;
  s1_t  s1_d;

  logic [MANT_W-1:0] mant_n;
  logic              guard;
  logic              norm;
  logic [MANT_W:0]   rnd;

  logic [FP_W-1:0]   res_d;
  logic              ovf_d;
  logic              uf_d;

  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;

  // S1: normalize on the product MSB, then round half-up on the guard bit
  always_comb begin
    if (product_i[PROD_W-1]) begin
      mant_n = product_i[PROD_W-2:1];
      guard  = product_i[0];
      norm   = 1'b1;
    end else begin
      mant_n = product_i[MANT_W-1:0];
      guard  = 1'b0;
      norm   = 1'b0;
    end
    rnd = {1'b0, mant_n} + {{MANT_W{1'b0}}, guard};

    s1_d.sign = sign_xor_i;
    s1_d.zero = zero_flag_i;
    s1_d.mant = rnd[MANT_W-1:0];
    s1_d.exp  = E_W'(sum_exp_i) - E_W'(EXP_BIAS) + E_W'(norm) + E_W'(rnd[MANT_W]);
  end

  // S2: zero beats underflow beats overflow; sign always survives
  always_comb begin
    res_d = {s1_q.sign, {(EXP_W + MANT_W){1'b0}}};
    ovf_d = 1'b0;
    uf_d  = 1'b0;
    if (s1_q.zero) begin
      res_d = {s1_q.sign, {(EXP_W + MANT_W){1'b0}}};
    end else if ($signed(s1_q.exp) <= EXP_ZERO_E) begin
      uf_d = 1'b1;
    end else if ($signed(s1_q.exp) >= EXP_MAX_E) begin
      res_d = {s1_q.sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      res_d = {s1_q.sign, s1_q.exp[EXP_W-1:0], s1_q.mant};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      result_o <= '0;
      ovf_o    <= 1'b0;
      uf_o     <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      // Output registers clear when S2 empties so flags never linger
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result_o <= res_d;
          ovf_o    <= ovf_d;
          uf_o     <= uf_d;
        end else begin
          result_o <= '0;
          ovf_o    <= 1'b0;
          uf_o     <= 1'b0;
        end
      end
    end
  end

endmodule
